// File: rtl/matrix_scan_decoder.sv
// matrix_scan_decoder: debounces a one-hot row / column LED scan bus and rebuilds the GS x GS frame
module matrix_scan_decoder #(
  parameter int GS = 8,
  parameter bit ROW_POL = 1'b1,
  parameter bit COL_POL = 1'b1,
  parameter int SETTLE = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [GS-1:0]    row_i,
  input  logic [GS-1:0]    col_i,
  input  logic             e_dec_i,
  output logic [GS*GS-1:0] matrix_o,
  output logic             frame_valid_o,
  output logic             d_dec_o,
  output logic [1:0]       err_o
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state;
  logic [GS-1:0] r, c, row_q, col_q, seen, seen_nxt;
  logic [GS*GS-1:0] shadow, shadow_nxt;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [TW-1:0] tmo_cnt;
  logic same, accept, one_hot, multi_hot, complete;
  assign r = ROW_POL ? row_i : ~row_i;
  assign c = COL_POL ? col_i : ~col_i;
  always_comb begin
    same = (r == row_q) && (c == col_q);
    stab_nxt = !same ? '0 : (stab_cnt == SMAX ? SMAX : stab_cnt + 1'b1);
    accept = (stab_nxt == SMAX) && !(same && stab_cnt == SMAX);
    one_hot = (r != '0) && ((r & (r - 1'b1)) == '0);
    multi_hot = (r != '0) && !one_hot;
    seen_nxt = (accept && one_hot) ? (seen | r) : seen;
    for (int k = 0; k < GS; k++)
      shadow_nxt[k*GS +: GS] = (accept && one_hot && r[k]) ? c : shadow[k*GS +: GS];
    complete = accept && one_hot && (&seen_nxt);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state <= IDLE;
      matrix_o <= '0;
      frame_valid_o <= 1'b0;
      d_dec_o <= 1'b0;
      err_o <= '0;
      shadow <= '0;
      seen <= '0;
      row_q <= '0;
      col_q <= '0;
      stab_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      row_q <= r;
      col_q <= c;
      stab_cnt <= stab_nxt;
      frame_valid_o <= 1'b0;
      case (state)
        IDLE: if (e_dec_i) begin
          state <= CAPTURE;
          seen <= '0;
          err_o <= '0;
          tmo_cnt <= '0;
          stab_cnt <= '0;
        end
        CAPTURE: if (!e_dec_i) state <= IDLE;
        else begin
          tmo_cnt <= (tmo_cnt == TMAX) ? TMAX : tmo_cnt + 1'b1;
          seen <= seen_nxt;
          shadow <= shadow_nxt;
          if (accept && multi_hot) err_o[0] <= 1'b1;
          if (complete) begin
            matrix_o <= shadow_nxt;
            frame_valid_o <= 1'b1;
            d_dec_o <= 1'b1;
            state <= DONE;
          end else if (tmo_cnt == TMAX) begin
            err_o[1] <= 1'b1;
            d_dec_o <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!e_dec_i) begin
          state <= IDLE;
          d_dec_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
